// File: rtl/valid_array_ctrl_pkg.sv
// Shared types for the valid-array sequencer/arbiter.
// State and requester ids used by the RR pointer.
package valid_array_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef enum logic {
    REQ_FILL   = 1'b0,
    REQ_LOOKUP = 1'b1
  } req_id_t;

endpackage

// File: rtl/valid_array_ctrl_rr_arbiter_2.sv
// Two-requester round-robin arbiter.
// Pointer names the winner under contention.
module rr_arbiter_2
  import valid_array_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    ptr,
  input  logic       enable,
  output logic [1:0] grant,
  output req_id_t    ptr_next
);

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    if (enable) begin
      if (req[REQ_FILL] && req[REQ_LOOKUP]) begin
        grant[ptr] = 1'b1;
        ptr_next   = (ptr == REQ_FILL) ? REQ_LOOKUP
                                       : REQ_FILL;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/valid_array_ctrl.sv
// Owns the valid_array port: fill/lookup RR
// arbitration plus a whole-array invalidate sweep.
module valid_array_ctrl
  import valid_array_ctrl_pkg::*;
#(
  parameter int NUMBER_SETS = 64,
  parameter int NUMBER_WAYS = 16,
  parameter int SET_PTR_WIDTH_IN_BITS =
    $clog2(NUMBER_SETS)
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic flush_req_in,
  output logic flush_busy_out,
  output logic flush_done_out,
  input  logic fill_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] fill_set_in,
  input  logic [NUMBER_WAYS-1:0] fill_way_in,
  input  logic fill_element_in,
  output logic fill_ready_out,
  input  logic lookup_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] lookup_set_in,
  output logic lookup_ready_out,
  output logic lookup_resp_valid_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]
    lookup_resp_set_out,
  output logic [NUMBER_WAYS-1:0] lookup_resp_bits_out,
  output logic array_access_en_out,
  output logic array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]
    array_access_set_addr_out,
  output logic [NUMBER_WAYS-1:0]
    array_write_way_select_out,
  output logic array_write_element_out,
  input  logic [NUMBER_WAYS-1:0] array_read_set_valid_in
);

  typedef logic [SET_PTR_WIDTH_IN_BITS-1:0] set_t;

  // Equality compare, so non-power-of-two set counts work.
  localparam set_t LAST_SET = set_t'(NUMBER_SETS - 1);

  state_t  state_q, state_d;
  set_t    cnt_q, cnt_d;
  req_id_t ptr_q, ptr_d;
  logic    done_q, done_d;
  logic    resp_valid_q;
  set_t    resp_set_q;
  logic    arb_en;
  logic [1:0] req, grant;

  assign arb_en = !reset_in && (state_q == IDLE)
                  && !flush_req_in;

  always_comb begin
    req = '0;
    req[REQ_FILL]   = fill_valid_in;
    req[REQ_LOOKUP] = lookup_valid_in;
  end

  rr_arbiter_2 u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .enable   (arb_en),
    .grant    (grant),
    .ptr_next (ptr_d)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= REQ_LOOKUP;
      done_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_set_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      done_q       <= done_d;
      resp_valid_q <= grant[REQ_LOOKUP];
      if (grant[REQ_LOOKUP])
        resp_set_q <= lookup_set_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req_in) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == LAST_SET) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + set_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    array_access_en_out        = 1'b0;
    array_write_en_out         = 1'b0;
    array_access_set_addr_out  = '0;
    array_write_way_select_out = '0;
    array_write_element_out    = 1'b0;
    if (!reset_in) begin
      unique case (1'b1)
        state_q == FLUSH: begin
          array_access_en_out        = 1'b1;
          array_write_en_out         = 1'b1;
          array_access_set_addr_out  = cnt_q;
          array_write_way_select_out = '1;
        end
        grant[REQ_FILL]: begin
          array_access_en_out        = 1'b1;
          array_write_en_out         = 1'b1;
          array_access_set_addr_out  = fill_set_in;
          array_write_way_select_out = fill_way_in;
          array_write_element_out    = fill_element_in;
        end
        grant[REQ_LOOKUP]: begin
          array_access_en_out        = 1'b1;
          array_access_set_addr_out  = lookup_set_in;
        end
        default: ;
      endcase
    end
  end

  assign fill_ready_out   = grant[REQ_FILL];
  assign lookup_ready_out = grant[REQ_LOOKUP];
  assign flush_busy_out   = !reset_in && (state_q == FLUSH);
  assign flush_done_out   = !reset_in && done_q;

  assign lookup_resp_valid_out = !reset_in && resp_valid_q;
  assign lookup_resp_set_out   =
    lookup_resp_valid_out ? resp_set_q : '0;
  assign lookup_resp_bits_out  =
    lookup_resp_valid_out ? array_read_set_valid_in : '0;

endmodule

// File: tb/tb_valid_array_ctrl.sv
// Bench for valid_array_ctrl with a behavioural array
// and a transaction-level reference of expected traffic.
module tb_valid_array_ctrl;

  localparam int NS = 64;
  localparam int NW = 16;
  localparam int SW = 6;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset_in, flush_req_in;
  logic flush_busy_out, flush_done_out;
  logic fill_valid_in, fill_element_in, fill_ready_out;
  logic [SW-1:0] fill_set_in, lookup_set_in;
  logic [NW-1:0] fill_way_in;
  logic lookup_valid_in, lookup_ready_out;
  logic lookup_resp_valid_out;
  logic [SW-1:0] lookup_resp_set_out;
  logic [NW-1:0] lookup_resp_bits_out;
  logic array_access_en_out, array_write_en_out;
  logic [SW-1:0] array_access_set_addr_out;
  logic [NW-1:0] array_write_way_select_out;
  logic array_write_element_out;
  logic [NW-1:0] array_read_set_valid_in;

  valid_array_ctrl #(
    .NUMBER_SETS(NS),
    .NUMBER_WAYS(NW),
    .SET_PTR_WIDTH_IN_BITS(SW)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .flush_req_in(flush_req_in),
    .flush_busy_out(flush_busy_out),
    .flush_done_out(flush_done_out),
    .fill_valid_in(fill_valid_in),
    .fill_set_in(fill_set_in),
    .fill_way_in(fill_way_in),
    .fill_element_in(fill_element_in),
    .fill_ready_out(fill_ready_out),
    .lookup_valid_in(lookup_valid_in),
    .lookup_set_in(lookup_set_in),
    .lookup_ready_out(lookup_ready_out),
    .lookup_resp_valid_out(lookup_resp_valid_out),
    .lookup_resp_set_out(lookup_resp_set_out),
    .lookup_resp_bits_out(lookup_resp_bits_out),
    .array_access_en_out(array_access_en_out),
    .array_write_en_out(array_write_en_out),
    .array_access_set_addr_out(array_access_set_addr_out),
    .array_write_way_select_out(array_write_way_select_out),
    .array_write_element_out(array_write_element_out),
    .array_read_set_valid_in(array_read_set_valid_in)
  );

  // Behavioural valid_array: registered read, masked write.
  logic [NW-1:0] amem [NS] = '{default: '0};
  logic [NW-1:0] ard = '0;
  always @(posedge clk_in) begin
    if (array_access_en_out) begin
      if (array_write_en_out)
        amem[array_access_set_addr_out] <=
          (amem[array_access_set_addr_out]
           & ~array_write_way_select_out)
          | (array_write_way_select_out
             & {NW{array_write_element_out}});
      else
        ard <= amem[array_access_set_addr_out];
    end
  end
  assign array_read_set_valid_in = ard;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference: expected array contents and traffic state.
  logic [NW-1:0] rmem [NS] = '{default: '0};
  int flush_left = 0;
  int sweep = 0;
  bit favor_lk = 1'b1;
  bit pend = 1'b0;
  int pend_set = 0;
  logic [NW-1:0] pend_bits = '0;
  bit done_pend = 1'b0;

  task automatic step(input bit fv, input int fs,
                      input int fw, input bit fe,
                      input bit lv, input int ls,
                      input bit fr, input bit rst);
    bit eb, ef, el, een, ewe, eel, erv;
    int eaddr;
    logic [NW-1:0] eway;
    eb = 0; ef = 0; el = 0; een = 0; ewe = 0;
    eel = 0; eaddr = 0; eway = '0;
    reset_in        = rst;
    flush_req_in    = fr;
    fill_valid_in   = fv;
    fill_set_in     = SW'(fs);
    fill_way_in     = NW'(1) << fw;
    fill_element_in = fe;
    lookup_valid_in = lv;
    lookup_set_in   = SW'(ls);
    @(negedge clk_in);
    if (!rst) begin
      eb = (flush_left > 0);
      if (eb) begin
        een = 1; ewe = 1; eaddr = sweep; eway = '1;
      end else if (!fr) begin
        if (fv && lv) begin
          el = favor_lk;
          ef = !favor_lk;
        end else begin
          ef = fv;
          el = lv;
        end
        if (ef) begin
          een = 1; ewe = 1; eaddr = fs;
          eway = NW'(1) << fw; eel = fe;
        end
        if (el) begin
          een = 1; eaddr = ls;
        end
      end
    end
    erv = !rst && pend;
    chk("fill_ready", 32'(fill_ready_out), 32'(ef));
    chk("lookup_ready", 32'(lookup_ready_out), 32'(el));
    chk("busy", 32'(flush_busy_out), 32'(eb));
    chk("done", 32'(flush_done_out),
        32'(!rst && done_pend));
    chk("access_en", 32'(array_access_en_out), 32'(een));
    chk("write_en", 32'(array_write_en_out), 32'(ewe));
    if (een)
      chk("addr", 32'(array_access_set_addr_out),
          32'(eaddr));
    if (ewe) begin
      chk("way_sel", 32'(array_write_way_select_out),
          32'(eway));
      chk("element", 32'(array_write_element_out),
          32'(eel));
    end
    chk("resp_valid", 32'(lookup_resp_valid_out),
        32'(erv));
    if (erv) begin
      chk("resp_set", 32'(lookup_resp_set_out),
          32'(pend_set));
      chk("resp_bits", 32'(lookup_resp_bits_out),
          32'(pend_bits));
    end
    if (rst) begin
      flush_left = 0; sweep = 0; favor_lk = 1'b1;
      pend = 0; done_pend = 0;
    end else begin
      done_pend = (flush_left == 1);
      pend = el;
      if (el) begin
        pend_set  = ls;
        pend_bits = rmem[ls];
      end
      if (eb) begin
        rmem[sweep] = '0;
        sweep++;
        flush_left--;
      end else if (fr) begin
        flush_left = NS;
        sweep = 0;
      end else begin
        if (fv && lv) favor_lk = !favor_lk;
        if (ef) rmem[fs][fw] = fe;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_in = 1; flush_req_in = 0;
    fill_valid_in = 0; fill_set_in = '0;
    fill_way_in = '0; fill_element_in = 0;
    lookup_valid_in = 0; lookup_set_in = '0;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 1, 1, 2, 1, 1);

    step(1, 5, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    idle(2);

    for (int i = 0; i < 4; i++)
      step(1, 9 + i, i, 1, 1, 9 + i, 0, 0);
    idle(2);

    step(1, 7, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0);
    idle(2);

    for (int i = 0; i < 6; i++)
      step(1, i * 11, i, 1, 0, 0, 0, 0);
    step(1, 3, 2, 1, 1, 3, 1, 0);
    for (int i = 0; i < NS; i++)
      step(1, 4, 4, 1, 1, 4, i == 10, 0);
    idle(2);
    for (int i = 0; i < NS; i++)
      step(0, 0, 0, 0, 1, i, 0, 0);
    idle(2);

    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(20);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(NS + 3);

    for (int i = 0; i < 1500; i++) begin
      int fs, ls;
      fs = ($urandom_range(0, 3) == 0)
           ? int'($urandom_range(0, NS - 1))
           : int'($urandom_range(0, 7));
      ls = ($urandom_range(0, 3) == 0)
           ? int'($urandom_range(0, NS - 1))
           : int'($urandom_range(0, 7));
      step(bit'($urandom_range(0, 1)), fs,
           int'($urandom_range(0, NW - 1)),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), ls,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 299) == 0);
    end
    idle(NS + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
